voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_voice_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// voice_scheduler: three-voice key allocator with attack/sustain/release
// envelopes driven by a shared step prescaler. Voice outputs are plain
// register copies; event decoding acts on the current voice state so a voice
// retiring on a tick only becomes allocatable on the following cycle.
module voice_scheduler #(
    parameter int unsigned STEP_CYCLES = 2500000,
    parameter int unsigned MAX_SHIFT   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic [7:0] ev_key,
    output logic [7:0] note1,
    output logic [7:0] note2,
    output logic [7:0] note3,
    output logic [3:0] shift1,
    output logic [3:0] shift2,
    output logic [3:0] shift3,
    output logic [2:0] active,
    output logic       ev_drop
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_SUSTAIN = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int unsigned      CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [3:0]       SHIFT_MAX = 4'(MAX_SHIFT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q [3];
    logic [1:0]       state_d [3];
    logic [7:0]       key_q   [3];
    logic [7:0]       key_d   [3];
    logic [3:0]       shift_q [3];
    logic [3:0]       shift_d [3];
    logic             drop_q, drop_d;

    logic             tick;
    logic             accept;
    logic             on_hit, off_hit, free_hit, steal_hit;
    logic [1:0]       on_idx, off_idx, free_idx, steal_idx;
    logic [3:0]       steal_shift;

    // Free-running envelope step prescaler
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Voice candidate search on the current (pre-tick) voice state
    always_comb begin
        on_hit      = 1'b0;
        off_hit     = 1'b0;
        free_hit    = 1'b0;
        steal_hit   = 1'b0;
        on_idx      = '0;
        off_idx     = '0;
        free_idx    = '0;
        steal_idx   = '0;
        steal_shift = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!on_hit && state_q[i] != ST_IDLE && key_q[i] == ev_key) begin
                on_hit = 1'b1;
                on_idx = 2'(i);
            end
            if (!off_hit && (state_q[i] == ST_ATTACK || state_q[i] == ST_SUSTAIN)
                && key_q[i] == ev_key) begin
                off_hit = 1'b1;
                off_idx = 2'(i);
            end
            if (!free_hit && state_q[i] == ST_IDLE) begin
                free_hit = 1'b1;
                free_idx = 2'(i);
            end
            // Strict compare keeps the lowest index among equal shifts
            if (state_q[i] == ST_RELEASE && (!steal_hit || shift_q[i] > steal_shift)) begin
                steal_hit   = 1'b1;
                steal_idx   = 2'(i);
                steal_shift = shift_q[i];
            end
        end
    end

    // Next voice state: tick stepping first, then the event overrides its target voice
    always_comb begin
        accept = ev_valid && ev_ready;
        drop_d = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            key_d[i]   = key_q[i];
            shift_d[i] = shift_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    key_d[i]   = '0;
                    shift_d[i] = SHIFT_MAX;
                end
                ST_SUSTAIN: shift_d[i] = '0;
                ST_ATTACK: begin
                    if (tick) begin
                        if (shift_q[i] <= 4'd1) begin
                            shift_d[i] = '0;
                            state_d[i] = ST_SUSTAIN;
                        end else begin
                            shift_d[i] = shift_q[i] - 4'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (shift_q[i] >= SHIFT_MAX - 4'd1) begin
                            shift_d[i] = SHIFT_MAX;
                            state_d[i] = ST_IDLE;
                            key_d[i]   = '0;
                        end else begin
                            shift_d[i] = shift_q[i] + 4'd1;
                        end
                    end
                end
            endcase
        end

        if (accept && ev_key != 8'd0) begin
            if (ev_on) begin
                if (on_hit) begin
                    state_d[on_idx] = ST_ATTACK;
                    shift_d[on_idx] = shift_q[on_idx];
                    key_d[on_idx]   = key_q[on_idx];
                end else if (free_hit) begin
                    state_d[free_idx] = ST_ATTACK;
                    shift_d[free_idx] = SHIFT_MAX;
                    key_d[free_idx]   = ev_key;
                end else if (steal_hit) begin
                    state_d[steal_idx] = ST_ATTACK;
                    shift_d[steal_idx] = SHIFT_MAX;
                    key_d[steal_idx]   = ev_key;
                end else begin
                    drop_d = 1'b1;
                end
            end else if (off_hit) begin
                state_d[off_idx] = ST_RELEASE;
                shift_d[off_idx] = shift_q[off_idx];
                key_d[off_idx]   = key_q[off_idx];
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= ST_IDLE;
                key_q[i]   <= '0;
                shift_q[i] <= SHIFT_MAX;
            end
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                key_q[i]   <= key_d[i];
                shift_q[i] <= shift_d[i];
            end
        end
    end

    // Output mapping straight from the voice registers
    always_comb begin
        ev_ready = reset_n;
        ev_drop  = drop_q;
        note1    = key_q[0];
        note2    = key_q[1];
        note3    = key_q[2];
        shift1   = shift_q[0];
        shift2   = shift_q[1];
        shift3   = shift_q[2];
        for (int unsigned i = 0; i < 3; i++) begin
            active[i] = (state_q[i] != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed sequence with STEP_CYCLES = 4, so envelope
// ticks land on every 4th clock edge after reset release (edges 4, 8, ...).
module tb_voice_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [7:0] ev_key;
    logic [7:0] note1, note2, note3;
    logic [3:0] shift1, shift2, shift3;
    logic [2:0] active;
    logic       ev_drop;

    typedef struct {
        string       tag;
        logic [39:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned edges  = 0;

    voice_scheduler #(.STEP_CYCLES(4), .MAX_SHIFT(8)) dut (
        .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_key(ev_key),
        .note1(note1), .note2(note2), .note3(note3),
        .shift1(shift1), .shift2(shift2), .shift3(shift3),
        .active(active), .ev_drop(ev_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [7:0] n1, input logic [7:0] n2,
                                       input logic [7:0] n3, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [3:0] s3,
                                       input logic [2:0] act, input logic drp);
        return {n1, n2, n3, s1, s2, s3, act, drp};
    endfunction

    function automatic logic [39:0] snap();
        return {note1, note2, note3, shift1, shift2, shift3, active, ev_drop};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic run_to(input int unsigned n);
        while (edges < n) step();
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL scoreboard_empty: observed no entry required one entry");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (snap() === e.val) passed++;
        else $error("FAIL %s: observed %h required %h", e.tag, snap(), e.val);
    endtask

    task automatic expect_now(input string tag, input logic [39:0] v);
        exp_q.push_back('{tag, v});
        check_pop();
    endtask

    task automatic ev_step(input string tag, input logic on, input logic [7:0] key,
                           input logic [39:0] v);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_key   = key;
        exp_q.push_back('{tag, v});
        step();
        ev_valid = 1'b0;
        ev_key   = 8'd0;
        check_pop();
    endtask

    task automatic check_ready(input string tag, input logic v);
        checks++;
        assert (ev_ready === v) passed++;
        else $error("FAIL %s: observed %b required %b", tag, ev_ready, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_key   = 8'd0;
        repeat (3) step();
        expect_now("reset_state", mk(8'h00, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b000, 1'b0));
        check_ready("ready_in_reset", 1'b0);
        reset_n = 1'b1;
        edges   = 0;
        #1;
        check_ready("ready_after_reset", 1'b1);

        // Single note attack to sustain
        ev_step("on_3c", 1'b1, 8'h3C, mk(8'h3C, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b001, 1'b0));
        run_to(4);
        expect_now("attack_first_tick", mk(8'h3C, 8'h00, 8'h00, 4'd7, 4'd8, 4'd8, 3'b001, 1'b0));
        run_to(32);
        expect_now("attack_done", mk(8'h3C, 8'h00, 8'h00, 4'd0, 4'd8, 4'd8, 3'b001, 1'b0));

        // Release from sustain to idle
        ev_step("off_3c", 1'b0, 8'h3C, mk(8'h3C, 8'h00, 8'h00, 4'd0, 4'd8, 4'd8, 3'b001, 1'b0));
        run_to(60);
        expect_now("release_tick7", mk(8'h3C, 8'h00, 8'h00, 4'd7, 4'd8, 4'd8, 3'b001, 1'b0));
        run_to(64);
        expect_now("release_idle", mk(8'h00, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b000, 1'b0));

        // Fill all voices, then a fourth note is dropped
        ev_step("on_10", 1'b1, 8'h10, mk(8'h10, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b001, 1'b0));
        ev_step("on_20", 1'b1, 8'h20, mk(8'h10, 8'h20, 8'h00, 4'd8, 4'd8, 4'd8, 3'b011, 1'b0));
        ev_step("on_30", 1'b1, 8'h30, mk(8'h10, 8'h20, 8'h30, 4'd8, 4'd8, 4'd8, 3'b111, 1'b0));
        run_to(96);
        expect_now("all_sustain", mk(8'h10, 8'h20, 8'h30, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0));
        ev_step("on_40_drop", 1'b1, 8'h40, mk(8'h10, 8'h20, 8'h30, 4'd0, 4'd0, 4'd0, 3'b111, 1'b1));
        exp_q.push_back('{"drop_one_cycle", mk(8'h10, 8'h20, 8'h30, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0)});
        step();
        check_pop();

        // Steal a releasing voice
        ev_step("off_20", 1'b0, 8'h20, mk(8'h10, 8'h20, 8'h30, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0));
        run_to(104);
        expect_now("release_two_ticks", mk(8'h10, 8'h20, 8'h30, 4'd0, 4'd2, 4'd0, 3'b111, 1'b0));
        ev_step("on_40_steal", 1'b1, 8'h40, mk(8'h10, 8'h40, 8'h30, 4'd0, 4'd8, 4'd0, 3'b111, 1'b0));
        run_to(108);
        expect_now("stolen_attack", mk(8'h10, 8'h40, 8'h30, 4'd0, 4'd7, 4'd0, 3'b111, 1'b0));

        // Retrigger a releasing voice on a tick cycle
        ev_step("off_30", 1'b0, 8'h30, mk(8'h10, 8'h40, 8'h30, 4'd0, 4'd7, 4'd0, 3'b111, 1'b0));
        run_to(131);
        expect_now("pre_retrigger", mk(8'h10, 8'h40, 8'h30, 4'd0, 4'd2, 4'd5, 3'b111, 1'b0));
        ev_step("retrigger_on_tick", 1'b1, 8'h30, mk(8'h10, 8'h40, 8'h30, 4'd0, 4'd1, 4'd5, 3'b111, 1'b0));
        run_to(136);
        expect_now("retrigger_attack", mk(8'h10, 8'h40, 8'h30, 4'd0, 4'd0, 4'd4, 3'b111, 1'b0));

        // One-cycle reset with an event presented during it
        reset_n  = 1'b0;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_key   = 8'h55;
        #1;
        check_ready("ready_low_mid_reset", 1'b0);
        step();
        expect_now("mid_reset", mk(8'h00, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b000, 1'b0));
        reset_n  = 1'b1;
        ev_valid = 1'b0;
        ev_key   = 8'd0;
        edges    = 0;
        step();
        expect_now("no_pending_event", mk(8'h00, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b000, 1'b0));

        // Key 0 and unmatched note-off are ignored
        ev_step("on_key0", 1'b1, 8'h00, mk(8'h00, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b000, 1'b0));
        ev_step("off_unmatched", 1'b0, 8'h77, mk(8'h00, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b000, 1'b0));
        ev_step("on_after_reset", 1'b1, 8'h3C, mk(8'h3C, 8'h00, 8'h00, 4'd8, 4'd8, 4'd8, 3'b001, 1'b0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
